// File: rtl/keypad_pkg.sv
// Shared types and helpers for the parametrised keypad scanner.
// Holds the scan FSM state enum, default timing constants and key-map helpers.
// Ports: none (package only).
package keypad_pkg;

    typedef enum logic [1:0] {
        S_DRIVE  = 2'd0,
        S_SAMPLE = 2'd1,
        S_EVAL   = 2'd2
    } state_t;

    localparam int DEF_ROWS           = 4;
    localparam int DEF_COLS           = 4;
    localparam int DEF_SETTLE_CYCLES  = 50;
    localparam int DEF_DEBOUNCE_SCANS = 4;
    localparam int DEF_REPEAT_DELAY   = 100;
    localparam int DEF_REPEAT_RATE    = 25;

    // Key maps are zero-extended to this width before being handed to the helpers.
    localparam int MAX_KEYS = 256;

    // Width of a raw key index r*COLS + c; never narrower than one bit.
    function automatic int key_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_KEYS-1:0] map);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (map[i]) n++;
        end
        return n;
    endfunction

    // Lowest set bit of the map; only meaningful when exactly one bit is set.
    function automatic int first_index(input logic [MAX_KEYS-1:0] map);
        int idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (map[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
// Ports: clk/rst (sync active-high), raw (async input bus), synced (clk-domain copy).
// Latency two cycles; resets to all ones, which is the idle (no key) row level.
module keypad_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= '1;
            synced <= '1;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// ROWS x COLS matrix keypad scanner: column drive, debounced key map, single-key events.
// Ports: clk/rst (sync active-high), row_n (async active-low rows), col_n (active-low column
//   drive), key_code (raw index r*COLS+c), key_valid (1-cycle event), key_held, multi_key.
// Optional auto-repeat is compiled in when the macro KEYPAD_REPEAT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int COLS           = DEF_COLS,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
    localparam int KW            = key_width(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            multi_key
);

    localparam int NK = ROWS * COLS;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    if (SETTLE_CYCLES < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scanner: timing parameter out of range");
    end

    logic [ROWS-1:0] row_sync;

    keypad_sync2 #(.WIDTH(ROWS)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .raw    (row_n),
        .synced (row_sync)
    );

    state_t          state, state_nxt;
    logic [CW-1:0]   col_idx, col_nxt;
    logic [SW-1:0]   settle_cnt, settle_nxt;
    logic [COLS-1:0] col_drive_nxt;
    logic [NK-1:0]   scan_map, prev_map, committed;
    logic [DW-1:0]   stable_cnt, stable_nxt;
    logic            lockout;
    logic            scan_same;
    logic            commit_en;
    int unsigned     new_count;
    logic [KW-1:0]   new_index;

    // Column sequencing: each column is driven for SETTLE_CYCLES cycles plus the
    // sample cycle, then one undriven evaluation cycle closes the scan.
    always_comb begin
        state_nxt  = state;
        col_nxt    = col_idx;
        settle_nxt = settle_cnt;
        case (state)
            S_DRIVE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    settle_nxt = '0;
                    state_nxt  = S_SAMPLE;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (col_idx == CW'(COLS - 1)) begin
                    state_nxt = S_EVAL;
                end else begin
                    col_nxt   = col_idx + 1'b1;
                    state_nxt = S_DRIVE;
                end
            end
            S_EVAL: begin
                col_nxt   = '0;
                state_nxt = S_DRIVE;
            end
            default: begin
                col_nxt    = '0;
                settle_nxt = '0;
                state_nxt  = S_DRIVE;
            end
        endcase

        // col_n is registered from the next state so it is glitch-free at the pins
        // and sits at all ones while reset is held.
        col_drive_nxt = '1;
        if (state_nxt != S_EVAL) col_drive_nxt[col_nxt] = 1'b0;
    end

    // Debounce: the committed map only moves after DEBOUNCE_SCANS identical scans,
    // and only a genuinely different map counts as a commit (no re-firing).
    always_comb begin
        scan_same = (scan_map == prev_map);
        if (!scan_same)                               stable_nxt = DW'(1);
        else if (stable_cnt == DW'(DEBOUNCE_SCANS))   stable_nxt = stable_cnt;
        else                                          stable_nxt = stable_cnt + 1'b1;
        commit_en = (state == S_EVAL) && (stable_nxt == DW'(DEBOUNCE_SCANS)) &&
                    (scan_map != committed);
        new_count = popcount(MAX_KEYS'(scan_map));
        new_index = KW'(first_index(MAX_KEYS'(scan_map)));
    end

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rep_cnt;
    logic        rep_started;
    logic [15:0] rep_inc;
    logic [15:0] rep_target;

    always_comb begin
        rep_inc    = rep_cnt + 16'd1;
        rep_target = rep_started ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_DRIVE;
            col_idx    <= '0;
            settle_cnt <= '0;
            col_n      <= '1;
            scan_map   <= '0;
            prev_map   <= '0;
            committed  <= '0;
            stable_cnt <= '0;
            lockout    <= 1'b0;
            key_code   <= '0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
            multi_key  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
            rep_started <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            col_idx    <= col_nxt;
            settle_cnt <= settle_nxt;
            col_n      <= col_drive_nxt;
            key_valid  <= 1'b0;

            if (state == S_SAMPLE) begin
                for (int k = 0; k < NK; k++) begin
                    if (col_idx == CW'(k % COLS)) scan_map[k] <= ~row_sync[k / COLS];
                end
            end

            if (state == S_EVAL) begin
                stable_cnt <= stable_nxt;
                if (!scan_same) prev_map <= scan_map;

                if (commit_en) begin
                    committed <= scan_map;
                    if (new_count == 0) begin
                        key_held  <= 1'b0;
                        multi_key <= 1'b0;
                        lockout   <= 1'b0;
                    end else if (new_count == 1) begin
                        multi_key <= 1'b0;
                        // A single key left over from a multi-key press stays silent
                        // until the pad has been fully released.
                        if (lockout) begin
                            key_held <= 1'b0;
                        end else begin
                            key_held  <= 1'b1;
                            key_code  <= new_index;
                            key_valid <= 1'b1;
                        end
                    end else begin
                        multi_key <= 1'b1;
                        key_held  <= 1'b0;
                        lockout   <= 1'b1;
                    end
                end

`ifdef KEYPAD_REPEAT_EN
                if (commit_en) begin
                    rep_cnt     <= '0;
                    rep_started <= 1'b0;
                end else if (key_held) begin
                    if (rep_inc == rep_target) begin
                        key_valid   <= 1'b1;
                        rep_cnt     <= '0;
                        rep_started <= 1'b1;
                    end else begin
                        rep_cnt <= rep_inc;
                    end
                end
`endif
            end
        end
    end

endmodule
